// File: rtl/uart_pkg.sv
// uart_pkg: shared state encodings and constants for uart_core.
// Parity state is only reached when UART_PARITY_EN is defined.
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam int   BIT_IDX_W  = $clog2(DATA_BITS);

  typedef logic [BIT_IDX_W-1:0] bit_idx_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter with mid-bit and
// end-of-bit strobes; restart_i starts a fresh period, clear_i stops it.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  input  logic clear_i,
  output logic mid_o,
  output logic end_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic          wrap;

  assign wrap = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (restart_i) begin
      cnt_d = '0;
      run_d = 1'b1;
    end else if (clear_i) begin
      cnt_d = '0;
      run_d = 1'b0;
    end else if (run_q) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign mid_o = run_q & (cnt_q == CW'(CLKS_PER_BIT / 2 - 1));
  assign end_o = run_q & wrap;

endmodule

// File: rtl/uart_core.sv
// uart_core: full-duplex 8N1 UART, optional even parity bit.
// Define UART_PARITY_EN to honour parity_enable; otherwise it is ignored.
module uart_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_pin,
  input  logic       send_request,
  input  logic [7:0] tx_data,
  input  logic       parity_enable,
  output logic [7:0] rx_data,
  output logic       data_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       tx_pin,
  output logic       tx_busy,
  output logic       tx_done
);

  tx_state_t  tx_state_q, tx_state_d;
  bit_idx_t   tx_bit_q, tx_bit_d;
  logic [7:0] tx_buf_q;
  logic       tx_pend_q;
  logic       tx_restart, tx_clear, tx_end;
  logic       tx_mid_unused;

  rx_state_t  rx_state_q, rx_state_d;
  bit_idx_t   rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rdy_q, rdy_d;
  logic       ferr_q, ferr_d;
  logic [1:0] sync_q;
  logic       prev_q;
  logic       rx_s, rx_fall;
  logic       rx_restart, rx_clear, rx_mid;
  logic       rx_end_unused;

`ifdef UART_PARITY_EN
  logic tx_par_q;
  logic rx_par_q;
  logic pbad_q, pbad_d;
  logic perr_q, perr_d;
`else
  logic unused_parity_enable;
  assign unused_parity_enable = parity_enable;
`endif

  assign tx_busy = tx_pend_q | (tx_state_q != TX_IDLE);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk_i    (clk),
    .rst_i    (reset),
    .restart_i(tx_restart),
    .clear_i  (tx_clear),
    .mid_o    (tx_mid_unused),
    .end_o    (tx_end)
  );

  // Capture stays live during reset so a request overlapping reset survives.
  always_ff @(posedge clk) begin
    if (send_request && (reset || !tx_busy))
      tx_buf_q <= tx_data;
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_bit_q   <= '0;
      tx_pend_q  <= send_request;
    end else begin
      tx_state_q <= tx_state_d;
      tx_bit_q   <= tx_bit_d;
      if (tx_restart)
        tx_pend_q <= 1'b0;
      else if (send_request && !tx_busy)
        tx_pend_q <= 1'b1;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset)
      tx_par_q <= 1'b0;
    else if (tx_restart)
      tx_par_q <= parity_enable;
  end
`endif

  always_comb begin
    tx_state_d = tx_state_q;
    tx_bit_d   = tx_bit_q;
    tx_restart = 1'b0;
    tx_clear   = 1'b0;
    tx_done    = 1'b0;
    tx_pin     = IDLE_LEVEL;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_pend_q && !reset) begin
          tx_state_d = TX_START;
          tx_restart = 1'b1;
        end
      end
      TX_START: begin
        tx_pin = 1'b0;
        if (tx_end) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = '0;
        end
      end
      TX_DATA: begin
        tx_pin = tx_buf_q[tx_bit_q];
        if (tx_end) begin
          tx_bit_d = tx_bit_q + 1'b1;
          if (tx_bit_q == BIT_IDX_W'(DATA_BITS - 1))
`ifdef UART_PARITY_EN
            tx_state_d = tx_par_q ? TX_PARITY : TX_STOP;
`else
            tx_state_d = TX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        tx_pin = ^tx_buf_q;
        if (tx_end)
          tx_state_d = TX_STOP;
      end
`endif
      TX_STOP: begin
        if (tx_end) begin
          tx_state_d = TX_IDLE;
          tx_clear   = 1'b1;
          tx_done    = !reset;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk_i    (clk),
    .rst_i    (reset),
    .restart_i(rx_restart),
    .clear_i  (rx_clear),
    .mid_o    (rx_mid),
    .end_o    (rx_end_unused)
  );

  assign rx_s    = sync_q[1];
  assign rx_fall = prev_q & ~rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= 2'b11;
      prev_q     <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rdy_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx_pin};
      prev_q     <= rx_s;
      rx_state_q <= rx_state_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rdy_q      <= rdy_d;
      ferr_q     <= ferr_d;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_par_q <= 1'b0;
      pbad_q   <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      if (rx_restart)
        rx_par_q <= parity_enable;
      pbad_q <= pbad_d;
      perr_q <= perr_d;
    end
  end
`endif

  always_comb begin
    rx_state_d = rx_state_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    ferr_d     = ferr_q;
    rdy_d      = 1'b0;
    rx_restart = 1'b0;
    rx_clear   = 1'b0;
`ifdef UART_PARITY_EN
    pbad_d     = pbad_q;
    perr_d     = perr_q;
`endif
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d = RX_START;
          rx_restart = 1'b1;
        end
      end
      RX_START: begin
        // A line back high at mid-start is a glitch, not a frame.
        if (rx_mid) begin
          if (rx_s) begin
            rx_state_d = RX_IDLE;
            rx_clear   = 1'b1;
          end else begin
            rx_state_d = RX_DATA;
            rx_bit_d   = '0;
          end
        end
      end
      RX_DATA: begin
        if (rx_mid) begin
          rx_sh_d  = {rx_s, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 1'b1;
          if (rx_bit_q == BIT_IDX_W'(DATA_BITS - 1))
`ifdef UART_PARITY_EN
            rx_state_d = rx_par_q ? RX_PARITY : RX_STOP;
`else
            rx_state_d = RX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_mid) begin
          pbad_d     = rx_s ^ (^rx_sh_q);
          rx_state_d = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (rx_mid) begin
          rx_state_d = RX_IDLE;
          rx_clear   = 1'b1;
          rx_data_d  = rx_sh_q;
          ferr_d     = ~rx_s;
          rdy_d      = 1'b1;
`ifdef UART_PARITY_EN
          perr_d     = rx_par_q & pbad_q;
`endif
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign rx_data    = rx_data_q;
  assign data_ready = rdy_q;
  assign frame_err  = ferr_q;
`ifdef UART_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed loopback and bench-driven frames for uart_core,
// received bytes checked against a scoreboard queue.
module tb_uart_core;

  localparam int N = 4;
`ifdef UART_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       send_request;
  logic [7:0] tx_data;
  logic       parity_enable;
  logic       loop;
  logic       rx_drv;
  logic       rx_line;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       parity_err;
  logic       frame_err;
  logic       tx_pin;
  logic       tx_busy;
  logic       tx_done;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   rdy_cnt = 0;

  assign rx_line = loop ? tx_pin : rx_drv;

  uart_core #(.CLKS_PER_BIT(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_pin       (rx_line),
    .send_request (send_request),
    .tx_data      (tx_data),
    .parity_enable(parity_enable),
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .tx_pin       (tx_pin),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (data_ready === 1'b1) begin
      rdy_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_ready", data_ready, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        chk("rx_data", rx_data, mon_e.d);
        chk("parity_err", parity_err, mon_e.pe);
        chk("frame_err", frame_err, mon_e.fe);
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic pe,
                      input logic expect_rx);
    parity_enable = pe;
    tx_data       = b;
    send_request  = 1'b1;
    if (expect_rx)
      sb.push_back('{b, 1'b0, 1'b0});
    @(negedge clk);
    send_request = 1'b0;
  endtask

  task automatic measure_frame(input int exp_len, input string tag);
    int n = 0;
    int t = 0;
    while (tx_pin !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    n = 1;
    while (tx_done !== 1'b1 && t < 400) begin
      @(negedge clk);
      n++;
      t++;
    end
    chk(tag, n, exp_len);
  endtask

  task automatic wait_rdy(input int target, input string tag);
    int t = 0;
    while (rdy_cnt < target && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(tag, rdy_cnt, target);
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (tx_done !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(tag, tx_done, 1'b1);
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic with_par,
                          input logic inv, input logic stop);
    rx_drv = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (N) @(negedge clk);
    end
    if (with_par) begin
      rx_drv = (^b) ^ inv;
      repeat (N) @(negedge clk);
    end
    rx_drv = stop;
    repeat (N) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * N) @(negedge clk);
  endtask

  initial begin
    int t;
    reset         = 1'b1;
    send_request  = 1'b0;
    tx_data       = 8'h00;
    parity_enable = 1'b0;
    loop          = 1'b1;
    rx_drv        = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tx_pin", tx_pin, 1'b1);
    chk("rst_tx_busy", tx_busy, 1'b0);
    chk("rst_tx_done", tx_done, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_data_ready", data_ready, 1'b0);
    chk("rst_parity_err", parity_err, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);

    // request overlapping reset
    send_request  = 1'b1;
    tx_data       = 8'hD3;
    parity_enable = 1'b1;
    sb.push_back('{8'hD3, 1'b0, 1'b0});
    @(negedge clk);
    reset        = 1'b0;
    send_request = 1'b0;
    chk("t1_busy_after_reset", tx_busy, 1'b1);
    measure_frame(PAR ? 44 : 40, "t1_frame_len");
    wait_rdy(1, "t1_ready");

    send(8'h55, 1'b0, 1'b1);
    measure_frame(40, "t2_frame_len");
    @(negedge clk);
    chk("t2_busy_drop", tx_busy, 1'b0);
    wait_rdy(2, "t2_ready");

    loop          = 1'b0;
    parity_enable = 1'b1;
    sb.push_back('{8'hA5, PAR, 1'b0});
    drive_rx(8'hA5, PAR, 1'b1, 1'b1);
    wait_rdy(3, "t3_ready");

    parity_enable = 1'b0;
    sb.push_back('{8'h3C, 1'b0, 1'b1});
    drive_rx(8'h3C, 1'b0, 1'b0, 1'b0);
    wait_rdy(4, "t4_ready");

    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_glitch_no_ready", rdy_cnt, 4);

    loop = 1'b1;
    send(8'h01, 1'b0, 1'b1);
    wait_done("t5_done1");
    @(negedge clk);
    chk("t5_idle_gap", tx_busy, 1'b0);
    send(8'hFE, 1'b0, 1'b1);
    wait_rdy(6, "t5_ready");

    send(8'h96, 1'b0, 1'b0);
    t = 0;
    while (tx_pin !== 1'b0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("t6_start", tx_pin, 1'b0);
    repeat (3 * N) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_tx_pin", tx_pin, 1'b1);
    chk("t6_tx_busy", tx_busy, 1'b0);
    repeat (60) @(negedge clk);
    chk("t6_no_ready", rdy_cnt, 6);
    send(8'h42, 1'b1, 1'b1);
    wait_rdy(7, "t6_ready");
    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
